// File: rtl/nondir_hazard_unit.sv
// Stall controller for conditional-write loads (lwld) whose destination is only known in MEM.
// Tracks in-flight lwld through E/M/W shadow slots and exports the resolved W-stage address.
module nondir_hazard_unit #(
  parameter logic [5:0] OP_LWLD  = 6'b110011,
  parameter logic [4:0] LINK_REG = 5'd31,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  input  logic             rs_use_d,
  input  logic             rt_use_d,
  input  logic             flush_e,
  input  logic [4:0]       wb_addr_m,
  output logic             stall,
  output logic             fwd_valid_w,
  output logic [4:0]       fwd_addr_w,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       is_lwld_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       unused_bits;

  logic       e_v;
  logic [4:0] e_rt;
  logic       m_v;
  logic       w_v;
  logic [4:0] w_addr;

  logic       rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
  logic       bubble_e;

  assign is_lwld_d   = (instr_d[31:26] == OP_LWLD);
  assign rs_d        = instr_d[25:21];
  assign rt_d        = instr_d[20:16];
  assign unused_bits = ^instr_d[15:0];

  // E-slot destination is unresolved: either rt or the link register may be written.
  assign rs_hit_e = rs_use_d && (rs_d != 5'd0) && e_v && ((rs_d == e_rt) || (rs_d == LINK_REG));
  assign rt_hit_e = rt_use_d && (rt_d != 5'd0) && e_v && ((rt_d == e_rt) || (rt_d == LINK_REG));
  // M-slot destination comes exact from the resolver.
  assign rs_hit_m = rs_use_d && (rs_d != 5'd0) && m_v && (rs_d == wb_addr_m);
  assign rt_hit_m = rt_use_d && (rt_d != 5'd0) && m_v && (rt_d == wb_addr_m);

  assign stall    = rs_hit_e || rt_hit_e || rs_hit_m || rt_hit_m;
  assign bubble_e = stall || flush_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_v       <= 1'b0;
      e_rt      <= 5'd0;
      m_v       <= 1'b0;
      w_v       <= 1'b0;
      w_addr    <= 5'd0;
      stall_cnt <= '0;
    end else begin
      e_v  <= bubble_e ? 1'b0 : is_lwld_d;
      e_rt <= bubble_e ? 5'd0 : rt_d;
      m_v  <= e_v;
      w_v  <= m_v;
      // Address only meaningful with w_v; keep the last resolved value otherwise.
      if (m_v) begin
        w_addr <= wb_addr_m;
      end
      if (stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign fwd_valid_w = w_v;
  assign fwd_addr_w  = w_addr;

endmodule
